// File: rtl/dmem_port_arbiter.sv
// Arbitrates one single-port synchronous data memory between execute-stage loads and
// store-buffer drain writes; loads win unless a store is starved or the buffer is draining.
module dmem_port_arbiter #(
  parameter int unsigned width_p        = 16,
  parameter int unsigned addr_width_p   = 16,
  parameter int unsigned sb_entries_p   = 8,
  parameter int unsigned starve_limit_p = 4
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 ld_v_i,
  input  logic [addr_width_p-1:0]              ld_addr_i,
  output logic                                 ld_ready_o,
  output logic                                 ld_data_v_o,
  output logic [width_p-1:0]                   ld_data_o,
  input  logic                                 st_v_i,
  input  logic [addr_width_p-1:0]              st_addr_i,
  input  logic [width_p-1:0]                   st_data_i,
  output logic                                 st_ready_o,
  input  logic [$clog2(sb_entries_p+1)-1:0]    sb_count_i,
  input  logic                                 flush_i,
  output logic                                 mem_v_o,
  output logic                                 mem_w_o,
  output logic [addr_width_p-1:0]              mem_addr_o,
  output logic [width_p-1:0]                   mem_data_o,
  input  logic [width_p-1:0]                   mem_data_i
);

  localparam int unsigned CntW = $clog2(sb_entries_p + 1);
  localparam logic [CntW-1:0] SbFull = CntW'(sb_entries_p);
  localparam logic [CntW-1:0] SbHalf = CntW'(sb_entries_p / 2);
  localparam logic [3:0] StarveLim = 4'(starve_limit_p);

  typedef enum logic [0:0] {StNormal, StDrain} state_e;

  state_e     state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       resp_pend_q, resp_pend_d;

  logic force_st;
  logic ld_ok;
  logic ld_gnt;
  logic st_gnt;

  // Grants are masked during reset so every output reads zero regardless of
  // the (possibly uninitialised) state registers.
  always_comb begin
    force_st = st_v_i & ((state_q == StDrain) | (starve_cnt_q == StarveLim));
    ld_ok    = ld_v_i & ~flush_i & ~force_st;
    ld_gnt   = ~reset_i & ld_ok;
    st_gnt   = ~reset_i & st_v_i & ~ld_ok;
  end

  always_comb begin
    ld_ready_o  = ld_gnt;
    st_ready_o  = st_gnt;
    mem_v_o     = ld_gnt | st_gnt;
    mem_w_o     = st_gnt;
    mem_addr_o  = '0;
    if (!reset_i) begin
      mem_addr_o = st_gnt ? st_addr_i : ld_addr_i;
    end
    mem_data_o  = st_gnt ? st_data_i : '0;
    ld_data_v_o = ~reset_i & resp_pend_q & ~flush_i;
    ld_data_o   = reset_i ? '0 : mem_data_i;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StNormal: if (sb_count_i == SbFull) state_d = StDrain;
      StDrain:  if (sb_count_i <= SbHalf) state_d = StNormal;
      default:  state_d = StNormal;
    endcase
  end

  // Counts consecutive cycles a valid store head lost to a load.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!st_v_i || st_gnt) begin
      starve_cnt_d = '0;
    end else if (ld_gnt && (starve_cnt_q != StarveLim)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  assign resp_pend_d = ld_gnt;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StNormal;
      starve_cnt_q <= '0;
      resp_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      resp_pend_q  <= resp_pend_d;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench: directed scenarios then random traffic against a cycle-level
// behavioural model of the arbitration rules and an attached synchronous memory.
module tb_dmem_port_arbiter;

  localparam int unsigned W   = 16;
  localparam int unsigned AW  = 16;
  localparam int unsigned SBE = 8;
  localparam int          LIM = 4;
  localparam int unsigned CW  = $clog2(SBE + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          ld_v;
  logic [AW-1:0] ld_addr;
  logic          ld_ready;
  logic          ld_data_v;
  logic [W-1:0]  ld_data;
  logic          st_v;
  logic [AW-1:0] st_addr;
  logic [W-1:0]  st_data;
  logic          st_ready;
  logic [CW-1:0] sb_count;
  logic          flush;
  logic          mem_v;
  logic          mem_w;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata;
  logic [W-1:0]  mem_rdata;

  dmem_port_arbiter #(
    .width_p        (W),
    .addr_width_p   (AW),
    .sb_entries_p   (SBE),
    .starve_limit_p (LIM)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .ld_v_i      (ld_v),
    .ld_addr_i   (ld_addr),
    .ld_ready_o  (ld_ready),
    .ld_data_v_o (ld_data_v),
    .ld_data_o   (ld_data),
    .st_v_i      (st_v),
    .st_addr_i   (st_addr),
    .st_data_i   (st_data),
    .st_ready_o  (st_ready),
    .sb_count_i  (sb_count),
    .flush_i     (flush),
    .mem_v_o     (mem_v),
    .mem_w_o     (mem_w),
    .mem_addr_o  (mem_addr),
    .mem_data_o  (mem_wdata),
    .mem_data_i  (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(int i);
    return (i == 16) ? 16'hBEEF : {8'hA5, 8'(i)};
  endfunction

  // Single-port synchronous RAM, read latency 1.
  logic [15:0] sram [0:255];
  logic        preload;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) sram[i] <= init_val(i);
    end else if (mem_v && mem_w) begin
      sram[mem_addr[7:0]] <= mem_wdata;
    end
    if (mem_v && !mem_w) mem_rdata <= sram[mem_addr[7:0]];
  end

  // Reference model state
  logic [15:0] m_mem [0:255];
  bit          m_drain;
  int          m_denied;
  bit          m_pend;
  logic [15:0] m_pend_data;
  bit          e_ld;
  bit          e_st;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Predict this cycle's outputs from the model and compare.
  task automatic predict_check();
    bit force_st;
    bit e_dv;
    #3;
    force_st = st_v && (m_drain || m_denied >= LIM);
    e_ld     = !reset && ld_v && !flush && !force_st;
    e_st     = !reset && st_v && !e_ld;
    e_dv     = !reset && m_pend && !flush;
    chk("ld_ready", 32'(ld_ready), 32'(e_ld));
    chk("st_ready", 32'(st_ready), 32'(e_st));
    chk("mem_v", 32'(mem_v), 32'(e_ld || e_st));
    chk("mem_w", 32'(mem_w), 32'(e_st));
    chk("mem_addr", 32'(mem_addr), reset ? 32'd0 : (e_st ? 32'(st_addr) : 32'(ld_addr)));
    chk("mem_data", 32'(mem_wdata), e_st ? 32'(st_data) : 32'd0);
    chk("ld_data_v", 32'(ld_data_v), 32'(e_dv));
    if (e_dv) chk("ld_data", 32'(ld_data), 32'(m_pend_data));
  endtask

  // Clock edge, then the model's state update for the cycle just checked.
  task automatic advance();
    @(posedge clk);
    if (reset) begin
      m_drain  = 1'b0;
      m_denied = 0;
      m_pend   = 1'b0;
    end else begin
      m_pend = e_ld;
      if (e_ld) m_pend_data = m_mem[ld_addr[7:0]];
      if (e_st) m_mem[st_addr[7:0]] = st_data;
      if (!st_v || e_st) m_denied = 0;
      else if (e_ld) m_denied = (m_denied + 1 > LIM) ? LIM : m_denied + 1;
      if (!m_drain && sb_count == CW'(SBE)) m_drain = 1'b1;
      else if (m_drain && sb_count <= CW'(SBE / 2)) m_drain = 1'b0;
    end
    #1;
  endtask

  task automatic set_in(input bit lv, input logic [15:0] la, input bit sv,
                        input logic [15:0] sa, input logic [15:0] sd,
                        input int sbc, input bit fl);
    ld_v = lv; ld_addr = la; st_v = sv; st_addr = sa; st_data = sd;
    sb_count = CW'(sbc); flush = fl;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = init_val(i);
    m_drain = 1'b0; m_denied = 0; m_pend = 1'b0; m_pend_data = '0;
    reset = 1'b1; preload = 1'b1;
    set_in(1, 16'h0010, 1, 16'h0020, 16'h5555, 0, 0);
    predict_check(); advance();
    preload = 1'b0;
    predict_check(); advance();
    reset = 1'b0;

    // Load of preloaded word, 1-cycle latency
    set_in(1, 16'h0010, 0, 16'h0, 16'h0, 0, 0);
    predict_check(); chk("t1_ld_ready", 32'(ld_ready), 32'd1); advance();
    set_in(0, 16'h0, 0, 16'h0, 16'h0, 0, 0);
    predict_check(); chk("t1_dv", 32'(ld_data_v), 32'd1);
    chk("t1_data", 32'(ld_data), 32'hBEEF); advance();

    // Store then load back
    set_in(0, 16'h0, 1, 16'h0020, 16'h1234, 1, 0);
    predict_check(); chk("t2_addr", 32'(mem_addr), 32'h20);
    chk("t2_wdata", 32'(mem_wdata), 32'h1234); advance();
    set_in(1, 16'h0020, 0, 16'h0, 16'h0, 0, 0);
    predict_check(); advance();
    set_in(0, 16'h0, 0, 16'h0, 16'h0, 0, 0);
    predict_check(); chk("t2_data", 32'(ld_data), 32'h1234); advance();

    // Starvation: store forced on the fifth contended cycle
    for (int i = 0; i < 7; i++) begin
      set_in(1, 16'(16'h0030 + i), 1, 16'h0040, 16'(16'hA000 + i), 3, 0);
      predict_check(); chk("t3_st_ready", 32'(st_ready), 32'(i == 4)); advance();
    end
    set_in(0, 16'h0, 0, 16'h0, 16'h0, 3, 0);
    predict_check(); advance();

    // Drain mode entry/exit by occupancy
    for (int i = 0; i < 6; i++) begin
      int sbc;
      sbc = (i < 2) ? 8 : (i == 2) ? 6 : (i == 3) ? 5 : 4;
      set_in(1, 16'h0011, 1, 16'(16'h0050 + i), 16'(16'hD000 + i), sbc, 0);
      predict_check();
      chk("t4_st_ready", 32'(st_ready), 32'(i >= 1 && i <= 4));
      advance();
    end

    // Flush kills the response and blocks acceptance
    set_in(1, 16'h0012, 0, 16'h0, 16'h0, 0, 0);
    predict_check(); advance();
    set_in(1, 16'h0013, 1, 16'h0060, 16'h7777, 0, 1);
    predict_check(); chk("t5_dv", 32'(ld_data_v), 32'd0);
    chk("t5_ld_ready", 32'(ld_ready), 32'd0); chk("t5_st_ready", 32'(st_ready), 32'd1);
    advance();

    // Reset mid-operation drops the pending response
    set_in(1, 16'h0014, 0, 16'h0, 16'h0, 0, 0);
    predict_check(); advance();
    reset = 1'b1;
    predict_check(); chk("t6_dv_rst", 32'(ld_data_v), 32'd0); advance();
    reset = 1'b0;
    set_in(0, 16'h0, 0, 16'h0, 16'h0, 0, 0);
    predict_check(); chk("t6_dv_after", 32'(ld_data_v), 32'd0); advance();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      set_in($urandom_range(0, 3) != 0, 16'($urandom_range(0, 255)),
             $urandom_range(0, 4) < 3, 16'($urandom_range(0, 255)), 16'($urandom),
             $urandom_range(0, 8), $urandom_range(0, 9) == 0);
      predict_check(); advance();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
